bp_fifo: RTL and testbench

BP_FIFO -- requirements
Module: bp_fifo

---
 rtl/bp_fifo.sv | 73 +++++++
 tb/tb_bp_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bp_fifo.sv
// Byte-pipe FIFO between the USB host side and a register-map device.
// Define BP_FIFO_BYPASS_EN to let a byte pass straight through an empty FIFO in the same cycle.
module bp_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cg,
  input  logic [7:0]                 i_bp_data,
  input  logic                       i_bp_valid,
  output logic                       o_bp_ready,
  output logic [7:0]                 o_bp_data,
  output logic                       o_bp_valid,
  input  logic                       i_bp_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [AW-1:0] wrIdx;
  logic [AW-1:0] rdIdx;
  logic          empty;
  logic          full;
  logic          bypassActive;
  logic          push;
  logic          pop;
  logic          doWrite;
  logic          doRead;

  assign wrIdx = wrPtr[AW-1:0];
  assign rdIdx = rdPtr[AW-1:0];
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrIdx == rdIdx) && (wrPtr[AW] != rdPtr[AW]);

`ifdef BP_FIFO_BYPASS_EN
  assign bypassActive = empty && i_bp_valid && i_cg && i_rst_n;
`else
  assign bypassActive = 1'b0;
`endif

  // Handshake qualifiers; nothing completes while gated or in reset
  assign o_bp_ready = i_cg && i_rst_n && !full;
  assign o_bp_valid = bypassActive || (i_cg && i_rst_n && !empty);
  assign o_bp_data  = bypassActive ? i_bp_data : mem[rdIdx];
  assign o_count    = PW'(wrPtr - rdPtr);

  assign push = i_bp_valid && o_bp_ready;
  assign pop  = o_bp_valid && i_bp_ready;

  // A bypassed byte consumed in the same cycle never touches storage
  assign doWrite = push && !(bypassActive && pop);
  assign doRead  = pop && !bypassActive;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= PW'(wrPtr + PW'(1));
      if (doRead)  rdPtr <= PW'(rdPtr + PW'(1));
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge i_clk) begin
    if (doWrite) mem[wrIdx] <= i_bp_data;
  end

endmodule

// File: tb/tb_bp_fifo.sv
// Directed self-checking bench for bp_fifo at DEPTH=4 in the default (non-bypass) build.
module tb_bp_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rstN;
  logic          cg;
  logic [7:0]    inData;
  logic          inValid;
  logic          outReady;
  logic [7:0]    outData;
  logic          outValid;
  logic          sinkReady;
  logic [PW-1:0] count;

  int checks = 0;
  int errors = 0;

  bp_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_cg       (cg),
    .i_bp_data  (inData),
    .i_bp_valid (inValid),
    .o_bp_ready (outReady),
    .o_bp_data  (outData),
    .o_bp_valid (outValid),
    .i_bp_ready (sinkReady),
    .o_count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fillBytes [4];
    logic [7:0] rx [16];
    int         tx;
    int         nRx;
    int         maxCount;

    fillBytes[0] = 8'h11; fillBytes[1] = 8'h22;
    fillBytes[2] = 8'h33; fillBytes[3] = 8'h44;

    rstN = 1'b0; cg = 1'b1; inData = 8'h00; inValid = 1'b0; sinkReady = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(outValid), 32'd0);
    chk("reset_ready", 32'(outReady), 32'd0);

    step(); step();
    rstN = 1'b1;
    #1;
    chk("post_reset_ready", 32'(outReady), 32'd1);
    step();

    // Fill with the sink stalled
    for (int i = 0; i < 4; i++) begin
      inData = fillBytes[i]; inValid = 1'b1;
      step();
    end
    inValid = 1'b0;
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(outReady), 32'd0);
    chk("fill_data", 32'(outData), 32'h11);
    chk("fill_valid", 32'(outValid), 32'd1);

    // Drain in order
    sinkReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_data%0d", i), 32'(outData), 32'(fillBytes[i]));
      step();
    end
    sinkReady = 1'b0;
    #1;
    chk("drain_valid", 32'(outValid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Refill, then offer a push while full and popping
    for (int i = 0; i < 4; i++) begin
      inData = 8'hA0 + 8'(i); inValid = 1'b1;
      step();
    end
    inData = 8'h55; inValid = 1'b1; sinkReady = 1'b1;
    #1;
    chk("full_pop_ready_before", 32'(outReady), 32'd0);
    step();
    inValid = 1'b0; sinkReady = 1'b0;
    #1;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready_after", 32'(outReady), 32'd1);
    chk("full_pop_head", 32'(outData), 32'hA1);

    // Asynchronous reset mid-operation, away from any edge
    #1;
    rstN = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(outValid), 32'd0);
    #1;
    rstN = 1'b1;
    step();
    chk("after_rst_count", 32'(count), 32'd0);

    // Stream 10 bytes across the pointer wrap
    tx = 0; nRx = 0; maxCount = 0;
    sinkReady = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      inValid = (tx < 10);
      inData  = 8'(tx);
      #1;
      if (outValid && sinkReady && nRx < 16) begin
        rx[nRx] = outData;
        nRx++;
      end
      if (inValid && outReady) tx++;
      if (int'(count) > maxCount) maxCount = int'(count);
      step();
    end
    inValid = 1'b0; sinkReady = 1'b0;
    chk("wrap_rx_count", 32'(nRx), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("wrap_byte%0d", i), 32'(rx[i]), 32'(i));
    chk("wrap_max_count", 32'(maxCount), 32'd1);
    chk("wrap_end_count", 32'(count), 32'd0);

    // Clock gate holds everything
    inData = 8'hC0; inValid = 1'b1; step();
    inData = 8'hC1; step();
    inValid = 1'b0;
    #1;
    chk("cg_pre_count", 32'(count), 32'd2);
    cg = 1'b0; inValid = 1'b1; inData = 8'hEE; sinkReady = 1'b1;
    #1;
    chk("cg_ready", 32'(outReady), 32'd0);
    chk("cg_valid", 32'(outValid), 32'd0);
    repeat (5) step();
    chk("cg_hold_count", 32'(count), 32'd2);
    cg = 1'b1; inValid = 1'b0; sinkReady = 1'b0;
    #1;
    chk("cg_head", 32'(outData), 32'hC0);
    chk("cg_valid_resume", 32'(outValid), 32'd1);
    chk("cg_post_count", 32'(count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
